// File: rtl/pkt_flow_stats_pkg.sv
// Shared types and helpers for the per-flow packet statistics block.
package pkt_flow_stats_pkg;

    localparam int PKT_CNT_W      = 32;
    localparam int BYTE_CNT_W     = 48;
    localparam int LEN_W          = 16;
    localparam int ERR_CNT_W      = 16;
    // Flow ids travel between parser and top zero-extended to this width.
    localparam int FLOW_IDX_MAX_W = 16;

    typedef struct packed {
        logic [PKT_CNT_W-1:0]  pkt_cnt;
        logic [BYTE_CNT_W-1:0] byte_cnt;
    } flow_stat_t;

    typedef struct packed {
        logic [FLOW_IDX_MAX_W-1:0] flow_num;
        logic [LEN_W-1:0]          len;
    } commit_t;

    // Index width for n flows; a single flow still gets a 1-bit index.
    function automatic int flow_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Packet length accumulation clamps at the 16-bit maximum.
    function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                     input logic [LEN_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_W] ? '1 : s[LEN_W-1:0];
    endfunction

    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pkt_flow_stats_if.sv
// Packet stream bundle: generator drives the master side, stats sink is the slave.
interface pkt_flow_stats_if #(
    parameter int DATA_W  = 64,
    parameter int FLOW_W  = 4,
    parameter int EMPTY_W = 3
);
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [FLOW_W-1:0]  flow_num;
    logic               valid;
    logic               ready;

    modport master (output data, sop, eop, empty, flow_num, valid, input ready);
    modport slave  (input data, sop, eop, empty, flow_num, valid, output ready);
endinterface

// File: rtl/pkt_flow_stats_parser.sv
// SOP/EOP framing FSM: accumulates packet length, counts framing errors and
// emits one registered commit per completed packet.
//
//  state  | meaning
//  IDLE   | between packets, expecting an SOP beat
//  IN_PKT | inside a packet, accumulating length for flow_q
module pkt_flow_stats_parser
    import pkt_flow_stats_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int FLOW_W  = 4,
    parameter int EMPTY_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 beat_acc_i,
    input  logic                 sop_i,
    input  logic                 eop_i,
    input  logic [EMPTY_W-1:0]   empty_i,
    input  logic [FLOW_W-1:0]    flow_num_i,
    output logic                 commit_valid_o,
    output commit_t              commit_o,
    output logic [ERR_CNT_W-1:0] err_sop_cnt_o,
    output logic [ERR_CNT_W-1:0] err_stray_cnt_o
);

    localparam int BPB = DATA_W / 8;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [FLOW_W-1:0] flow_q;
    logic [LEN_W-1:0]  beat_len;
    logic [LEN_W-1:0]  len_sum;

    // Bytes carried by the current beat and the running length including it.
    always_comb begin
        beat_len = eop_i ? (LEN_W'(BPB) - LEN_W'(empty_i)) : LEN_W'(BPB);
        len_sum  = len_sat_add(len_q, beat_len);
    end

    // Framing FSM; an SOP always starts a fresh packet, abandoning any open one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            len_q           <= '0;
            flow_q          <= '0;
            commit_valid_o  <= 1'b0;
            commit_o        <= '0;
            err_sop_cnt_o   <= '0;
            err_stray_cnt_o <= '0;
        end else begin
            commit_valid_o <= 1'b0;
            if (beat_acc_i) begin
                if (sop_i) begin
                    if (state == IN_PKT)
                        err_sop_cnt_o <= err_sat_inc(err_sop_cnt_o);
                    if (eop_i) begin
                        commit_valid_o <= 1'b1;
                        commit_o       <= '{flow_num: FLOW_IDX_MAX_W'(flow_num_i), len: beat_len};
                        state          <= IDLE;
                    end else begin
                        flow_q <= flow_num_i;
                        len_q  <= beat_len;
                        state  <= IN_PKT;
                    end
                end else if (state == IDLE) begin
                    err_stray_cnt_o <= err_sat_inc(err_stray_cnt_o);
                end else if (eop_i) begin
                    commit_valid_o <= 1'b1;
                    commit_o       <= '{flow_num: FLOW_IDX_MAX_W'(flow_q), len: len_sum};
                    state          <= IDLE;
                end else begin
                    len_q <= len_sum;
                end
            end
        end
    end

endmodule

// File: rtl/pkt_flow_stats.sv
// Per-flow packet/byte counters fed by the framing parser, with a one-cycle
// read port. Define PKT_FLOW_STATS_CLR_ON_RD_EN to make reads clear the
// addressed flow's counters.
module pkt_flow_stats
    import pkt_flow_stats_pkg::*;
#(
    parameter  int FLOW_CNT       = 16,
    parameter  int DATA_W         = 64,
    localparam int FLOW_CNT_WIDTH = flow_idx_w(FLOW_CNT),
    localparam int EMPTY_W        = $clog2(DATA_W / 8)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    pkt_flow_stats_if.slave           pkt,
    input  logic [FLOW_CNT_WIDTH-1:0] rd_addr_i,
    input  logic                      rd_req_i,
    output logic                      rd_valid_o,
    output logic [PKT_CNT_W-1:0]      rd_pkt_cnt_o,
    output logic [BYTE_CNT_W-1:0]     rd_byte_cnt_o,
    output logic [ERR_CNT_W-1:0]      err_sop_cnt_o,
    output logic [ERR_CNT_W-1:0]      err_stray_cnt_o
);

    logic       ready_q;
    logic       commit_valid;
    commit_t    commit;
    flow_stat_t stats_q [FLOW_CNT];
    flow_stat_t stats_d [FLOW_CNT];

    // The sink never stalls; ready only drops while in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    assign pkt.ready = ready_q;

    pkt_flow_stats_parser #(
        .DATA_W  (DATA_W),
        .FLOW_W  (FLOW_CNT_WIDTH),
        .EMPTY_W (EMPTY_W)
    ) u_parser (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .beat_acc_i      (pkt.valid & ready_q),
        .sop_i           (pkt.sop),
        .eop_i           (pkt.eop),
        .empty_i         (pkt.empty),
        .flow_num_i      (pkt.flow_num),
        .commit_valid_o  (commit_valid),
        .commit_o        (commit),
        .err_sop_cnt_o   (err_sop_cnt_o),
        .err_stray_cnt_o (err_stray_cnt_o)
    );

    // Next counter values: optional clear-on-read first, then the commit adds on
    // top, so a read and commit to the same flow in one cycle keep the increment.
    always_comb begin
        for (int i = 0; i < FLOW_CNT; i++) begin
            stats_d[i] = stats_q[i];
`ifdef PKT_FLOW_STATS_CLR_ON_RD_EN
            if (rd_req_i && (rd_addr_i == FLOW_CNT_WIDTH'(i)))
                stats_d[i] = '0;
`endif
            if (commit_valid && (commit.flow_num == FLOW_IDX_MAX_W'(i))) begin
                stats_d[i].pkt_cnt  = stats_d[i].pkt_cnt + PKT_CNT_W'(1);
                stats_d[i].byte_cnt = stats_d[i].byte_cnt + BYTE_CNT_W'(commit.len);
            end
        end
    end

    // Counter storage, updated every cycle from registered state so
    // back-to-back commits to one flow both land.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FLOW_CNT; i++) begin
            if (rst_i) stats_q[i] <= '0;
            else       stats_q[i] <= stats_d[i];
        end
    end

    // Read port returns the value held before any commit landing this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o    <= 1'b0;
            rd_pkt_cnt_o  <= '0;
            rd_byte_cnt_o <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) begin
                rd_pkt_cnt_o  <= stats_q[rd_addr_i].pkt_cnt;
                rd_byte_cnt_o <= stats_q[rd_addr_i].byte_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pkt_flow_stats.sv
// Self-checking bench for pkt_flow_stats: directed vector table, hand-written
// corner sequences and a randomized run against a packet-level model.
module tb_pkt_flow_stats;

    localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MASK48 = 64'h0000_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rd_addr = '0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pkt;
    logic [47:0] rd_byte;
    logic [15:0] err_sop;
    logic [15:0] err_stray;

    int n_tests = 0;
    int n_fail  = 0;

    pkt_flow_stats_if #(.DATA_W(64), .FLOW_W(4), .EMPTY_W(3)) pif ();

    pkt_flow_stats #(.FLOW_CNT(16), .DATA_W(64)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pkt             (pif),
        .rd_addr_i       (rd_addr),
        .rd_req_i        (rd_req),
        .rd_valid_o      (rd_valid),
        .rd_pkt_cnt_o    (rd_pkt),
        .rd_byte_cnt_o   (rd_byte),
        .err_sop_cnt_o   (err_sop),
        .err_stray_cnt_o (err_stray)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Packet-level reference: per-flow totals plus open-packet bookkeeping.
    longint m_pkt [16];
    longint m_byte[16];
    int     m_sop, m_stray;
    bit     m_in_pkt;
    int     m_flow, m_len;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int f = 0; f < 16; f++) begin
            m_pkt[f]  = 0;
            m_byte[f] = 0;
        end
        m_sop = 0; m_stray = 0; m_in_pkt = 0; m_flow = 0; m_len = 0;
    endtask

    task automatic model_commit(input int f, input int len);
        m_pkt[f]  = (m_pkt[f] + 1) & MASK32;
        m_byte[f] = (m_byte[f] + len) & MASK48;
    endtask

    task automatic model_beat(input bit sop, input bit eop, input int flow, input int empty);
        int b;
        b = eop ? 8 - empty : 8;
        if (sop) begin
            if (m_in_pkt && m_sop < 65535) m_sop++;
            if (eop) begin
                model_commit(flow, b);
                m_in_pkt = 0;
            end else begin
                m_in_pkt = 1; m_flow = flow; m_len = b;
            end
        end else if (!m_in_pkt) begin
            if (m_stray < 65535) m_stray++;
        end else begin
            m_len = (m_len + b > 65535) ? 65535 : m_len + b;
            if (eop) begin
                model_commit(m_flow, m_len);
                m_in_pkt = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_req = 1'b0;
        pif.valid = 1'b0; pif.sop = 1'b0; pif.eop = 1'b0;
        tick(); tick();
        chk("ready_in_reset", longint'(pif.ready), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", longint'(pif.ready), 1);
    endtask

    task automatic beat(input bit sop, input bit eop, input int flow, input int empty);
        pif.valid    = 1'b1;
        pif.sop      = sop;
        pif.eop      = eop;
        pif.flow_num = 4'(flow);
        pif.empty    = 3'(empty);
        pif.data     = {$urandom, $urandom};
        tick();
        pif.valid = 1'b0; pif.sop = 1'b0; pif.eop = 1'b0;
    endtask

    task automatic send_pkt(input int flow, input int beats, input int empty);
        for (int b = 0; b < beats; b++)
            beat(b == 0, b == beats - 1, flow, (b == beats - 1) ? empty : 0);
    endtask

    task automatic read_chk(input string name, input int flow, input longint ep, input longint eb);
        rd_addr = 4'(flow);
        rd_req  = 1'b1;
        tick();
        rd_req  = 1'b0;
        chk({name, "_valid"}, longint'(rd_valid), 1);
        chk({name, "_pkt"},   longint'(rd_pkt),   ep);
        chk({name, "_byte"},  longint'(rd_byte),  eb);
    endtask

    typedef struct {
        int     flow;
        int     beats;
        int     empty;
        int     reps;
        longint exp_pkt;
        longint exp_byte;
    } vec_t;

    vec_t vecs[4];

    initial begin
        pif.valid = 1'b0; pif.sop = 1'b0; pif.eop = 1'b0;
        pif.empty = '0; pif.flow_num = '0; pif.data = '0;

        vecs[0] = '{flow: 3,  beats: 8, empty: 0, reps: 1, exp_pkt: 1, exp_byte: 64};
        vecs[1] = '{flow: 0,  beats: 1, empty: 3, reps: 5, exp_pkt: 5, exp_byte: 25};
        vecs[2] = '{flow: 15, beats: 3, empty: 7, reps: 2, exp_pkt: 2, exp_byte: 34};
        vecs[3] = '{flow: 7,  beats: 2, empty: 0, reps: 3, exp_pkt: 3, exp_byte: 48};

        // Reset state
        do_reset();
        chk("rst_rd_valid",  longint'(rd_valid),  0);
        chk("rst_rd_pkt",    longint'(rd_pkt),    0);
        chk("rst_rd_byte",   longint'(rd_byte),   0);
        chk("rst_err_sop",   longint'(err_sop),   0);
        chk("rst_err_stray", longint'(err_stray), 0);

        // Vector table: back-to-back packets to one flow, neighbour stays empty
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int r = 0; r < vecs[v].reps; r++)
                send_pkt(vecs[v].flow, vecs[v].beats, vecs[v].empty);
            tick(); tick();
            read_chk($sformatf("vec%0d", v), vecs[v].flow, vecs[v].exp_pkt, vecs[v].exp_byte);
            read_chk($sformatf("vec%0d_other", v), (vecs[v].flow + 1) % 16, 0, 0);
        end
        tick();
        chk("rd_valid_drop", longint'(rd_valid), 0);

        // SOP inside a packet abandons it and restarts
        do_reset();
        beat(1, 0, 4, 0); beat(0, 0, 4, 0); beat(0, 0, 4, 0);
        beat(1, 1, 1, 4);
        tick(); tick();
        chk("sop_err_cnt", longint'(err_sop), 1);
        chk("sop_err_stray", longint'(err_stray), 0);
        read_chk("sop_new_flow", 1, 1, 4);
        read_chk("sop_old_flow", 4, 0, 0);

        // Stray beats while idle are dropped
        do_reset();
        beat(0, 0, 2, 0); beat(0, 1, 2, 1); beat(0, 0, 5, 0);
        tick(); tick();
        chk("stray_cnt", longint'(err_stray), 3);
        for (int f = 0; f < 16; f++) begin
            rd_addr = 4'(f); rd_req = 1'b1; tick(); rd_req = 1'b0;
            chk($sformatf("stray_flow%0d_pkt", f), longint'(rd_pkt), 0);
        end

        // Read in the same cycle a commit lands
        do_reset();
        send_pkt(2, 13, 4);
        tick(); tick();
        send_pkt(2, 8, 4);
        read_chk("rdc_first", 2, 1, 100);
`ifdef PKT_FLOW_STATS_CLR_ON_RD_EN
        read_chk("rdc_second", 2, 1, 60);
        read_chk("rdc_third", 2, 0, 0);
`else
        read_chk("rdc_second", 2, 2, 160);
        read_chk("rdc_third", 2, 2, 160);
`endif

        // Length accumulator saturation
        do_reset();
        send_pkt(9, 8200, 0);
        tick(); tick();
        read_chk("len_sat", 9, 1, 65535);

        // Byte counter wrap at 2^48
        do_reset();
        dut.stats_q[5].byte_cnt = 48'hFFFF_FFFF_FFF6;
        send_pkt(5, 8, 0);
        tick(); tick();
        read_chk("byte_wrap", 5, 1, 54);

        // Reset mid-packet: no commit, parser back to idle
        beat(1, 0, 6, 0); beat(0, 0, 6, 0); beat(0, 0, 6, 0);
        rst = 1'b1;
        beat(0, 1, 6, 0);
        tick();
        rst = 1'b0;
        tick();
        beat(0, 0, 6, 0); beat(0, 1, 6, 0);
        tick(); tick();
        read_chk("midrst_flow", 6, 0, 0);
        chk("midrst_err_sop", longint'(err_sop), 0);
        chk("midrst_err_stray", longint'(err_stray), 2);

        // Randomized traffic against the packet-level model
        for (int round = 0; round < 2; round++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < 2000; c++) begin
                if ($urandom_range(3) != 0) begin
                    bit s, e;
                    int fl, em;
                    s  = ($urandom_range(3) == 0);
                    e  = ($urandom_range(2) == 0);
                    fl = $urandom_range(15);
                    em = $urandom_range(7);
                    model_beat(s, e, fl, em);
                    beat(s, e, fl, em);
                end else begin
                    tick();
                end
            end
            tick(); tick(); tick();
            for (int f = 0; f < 16; f++)
                read_chk($sformatf("rnd%0d_flow%0d", round, f), f, m_pkt[f], m_byte[f]);
            chk($sformatf("rnd%0d_err_sop", round), longint'(err_sop), m_sop);
            chk($sformatf("rnd%0d_err_stray", round), longint'(err_stray), m_stray);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
